// File: rtl/display_pkg.sv
// Shared constants for the scanned 7-segment display: segment codes,
// segment bit positions and a constant-evaluable clog2.
package display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  // Active-low codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [SEG_W-1:0] SEG_DASH  = ~(SEG_W'(1) << SEG_G);
  localparam logic [SEG_W-1:0] SEG_BLANK = '1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_display_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode display driver with a tear-free frame latch
// and optional leading-zero blanking.
module bcd_scan_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [4*NUM_DIGITS-1:0]      digits,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [SEG_W-1:0]             seg,
  output logic                         dp,
  output logic [clog2(NUM_DIGITS)-1:0] scan_idx
);

  localparam int SW = clog2(NUM_DIGITS);
  localparam int PW = (REFRESH_DIV > 1) ? clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [SW-1:0]           r_scan_idx;
  logic [4*NUM_DIGITS-1:0] r_frame_digits;
  logic [NUM_DIGITS-1:0]   r_frame_dp;
  logic                    r_reload;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [SEG_W-1:0]        r_seg;
  logic                    r_dp;

  logic                    w_tick;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_frame_digits;
  logic [NUM_DIGITS-1:0]   w_frame_dp;
  logic [3:0]              w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [SEG_W-1:0]        w_seg;
  logic                    w_blank;

  assign w_tick = en && (r_presc == PRESC_MAX);
  assign w_wrap = w_tick && (r_scan_idx == LAST_IDX);

  // The cycle that takes a fresh frame also drives from it, so the first lit
  // digit after reset or enable already shows the new value.
  assign w_frame_digits = r_reload ? digits : r_frame_digits;
  assign w_frame_dp     = r_reload ? dp_in  : r_frame_dp;

  // w_lz[k]: digits k..NUM_DIGITS-1 of the frame are all zero
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_digit[gi] = w_frame_digits[4*gi +: 4];
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_lz[gi] = (w_digit[gi] == 4'd0);
      end else begin : g_low
        assign w_lz[gi] = (w_digit[gi] == 4'd0) && w_lz[gi+1];
      end
    end
  endgenerate

  bcd_to_seg u_dec (
    .bcd (w_digit[r_scan_idx]),
    .seg (w_seg)
  );

  assign w_blank = (BLANK_LZ != 0) && (r_scan_idx != '0) && w_lz[r_scan_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc        <= '0;
      r_scan_idx     <= '0;
      r_frame_digits <= '0;
      r_frame_dp     <= '0;
      r_reload       <= 1'b1;
      r_an           <= '1;
      r_seg          <= SEG_BLANK;
      r_dp           <= 1'b1;
    end else if (!en) begin
      r_presc    <= '0;
      r_scan_idx <= '0;
      r_reload   <= 1'b1;
      r_an       <= '1;
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_scan_idx <= w_wrap ? '0 : r_scan_idx + SW'(1);
      if (r_reload || w_wrap) begin
        r_frame_digits <= digits;
        r_frame_dp     <= dp_in;
      end
      r_reload <= 1'b0;
      r_an     <= ~(NUM_DIGITS'(1) << r_scan_idx);
      r_seg    <= w_blank ? SEG_BLANK : w_seg;
      r_dp     <= ~w_frame_dp[r_scan_idx];
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign scan_idx = r_scan_idx;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench: NUM_DIGITS=4 with REFRESH_DIV=4, plus a REFRESH_DIV=1 instance.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  an, an1;
  logic [6:0]  seg, seg1;
  logic        dp, dp1;
  logic [1:0]  scan_idx, scan_idx1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .scan_idx(scan_idx)
  );

  bcd_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1), .scan_idx(scan_idx1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("check %s obs=%0h exp=%0h", tag, obs, exp);
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    chk({tag, ".an"}, an, e_an);
    chk({tag, ".seg"}, seg, e_seg);
    chk({tag, ".dp"}, dp, e_dp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; digits = 16'h1234; dp_in = 4'b0000;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_disp("rst", 4'hF, 7'h7F, 1'b1);
      chk("rst.idx", scan_idx, 2'd0);
    end

    // Release: '4' on digit 0 for four cycles, then '3'; fast instance rotates each cycle
    rst_n = 1'b1;
    step(1); chk_disp("rel0", 4'hE, 7'h19, 1'b1); chk("div1.an0", an1, 4'hE);
    step(1); chk("rel.hold1", an, 4'hE);          chk("div1.an1", an1, 4'hD);
    step(1); chk("rel.hold2", an, 4'hE);          chk("div1.an2", an1, 4'hB);
    step(1); chk("rel.hold3", an, 4'hE);          chk("div1.an3", an1, 4'h7);
    chk("rel.idx1", scan_idx, 2'd1);
    step(1); chk_disp("rel1", 4'hD, 7'h30, 1'b1); chk("div1.an4", an1, 4'hE);

    // Full scan with a decimal point on digit 2 (fresh latch via enable toggle)
    en = 1'b0; digits = 16'h9876; dp_in = 4'b0100;
    step(1); chk_disp("en_off", 4'hF, 7'h7F, 1'b1);
    en = 1'b1;
    step(1); chk_disp("scan0", 4'hE, 7'h02, 1'b1);
    step(4); chk_disp("scan1", 4'hD, 7'h78, 1'b1);
    step(4); chk_disp("scan2", 4'hB, 7'h00, 1'b0);
    step(4); chk_disp("scan3", 4'h7, 7'h10, 1'b1);
    step(4); chk_disp("scan4", 4'hE, 7'h02, 1'b1);

    // Leading-zero blanking on 0050
    en = 1'b0; digits = 16'h0050; dp_in = 4'b0000;
    step(1);
    en = 1'b1;
    step(1); chk_disp("lz0", 4'hE, 7'h40, 1'b1);
    step(4); chk_disp("lz1", 4'hD, 7'h12, 1'b1);
    step(4); chk_disp("lz2", 4'hB, 7'h7F, 1'b1);
    step(4); chk_disp("lz3", 4'h7, 7'h7F, 1'b1);

    // All-zero value, latched at the frame wrap
    digits = 16'h0000;
    step(4); chk_disp("zero0", 4'hE, 7'h40, 1'b1);
    step(4); chk_disp("zero1", 4'hD, 7'h7F, 1'b1);
    step(4); chk_disp("zero2", 4'hB, 7'h7F, 1'b1);
    step(4); chk_disp("zero3", 4'h7, 7'h7F, 1'b1);

    // Illegal code, then a mid-frame change that must not tear the frame
    digits = 16'h00A1;
    step(4); chk_disp("ill0", 4'hE, 7'h79, 1'b1);
    digits = 16'h0002;
    step(4); chk_disp("ill1", 4'hD, 7'h3F, 1'b1);
    step(4); chk_disp("ill2", 4'hB, 7'h7F, 1'b1);
    chk("ill2.idx", scan_idx, 2'd2);
    step(4); chk_disp("ill3", 4'h7, 7'h7F, 1'b1);
    step(4); chk_disp("new0", 4'hE, 7'h24, 1'b1);

    // Drop enable in the middle of digit 2
    step(8); chk("mid2.an", an, 4'hB); chk("mid2.idx", scan_idx, 2'd2);
    en = 1'b0;
    step(1); chk_disp("drop", 4'hF, 7'h7F, 1'b1); chk("drop.idx", scan_idx, 2'd0);
    step(2); chk_disp("drop.hold", 4'hF, 7'h7F, 1'b1);
    en = 1'b1;
    step(1); chk_disp("rise0", 4'hE, 7'h24, 1'b1); chk("rise.idx0", scan_idx, 2'd0);
    step(1); chk("rise.idx1", scan_idx, 2'd0);
    step(1); chk("rise.idx2", scan_idx, 2'd0);
    step(1); chk("rise.idx3", scan_idx, 2'd1); chk("rise.an3", an, 4'hE);

    // Reset mid-scan overrides enable
    step(5);
    rst_n = 1'b0;
    step(1); chk_disp("rst2", 4'hF, 7'h7F, 1'b1); chk("rst2.idx", scan_idx, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
